// File: rtl/matrix_pkg.sv
// Shared definitions for the double-buffered LED matrix frame buffer.
// Optional feature macro: MATRIX_FB_COPY_EN (adds the post-swap back-bank copy).
package matrix_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ROWS_DEF   = 8;

   // Row index width; never below one bit so a single-row frame still has a port
   function automatic int addr_width(input int rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

   localparam int ADDR_W_DEF = addr_width(ROWS_DEF);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_FRAME = 2'd1,
      ST_SWAP       = 2'd2
`ifdef MATRIX_FB_COPY_EN
      ,ST_COPY      = 2'd3
`endif
   } fb_state_e;

endpackage

// File: rtl/matrix_fb_bank.sv
// One frame bank: ROWS x DATA_W registers, one synchronous write port,
// combinational display and copy read ports, synchronous clear.
module matrix_fb_bank
   import matrix_pkg::*;
#(
   parameter int  DATA_W = DATA_W_DEF,
   parameter int  ROWS   = ROWS_DEF,
   localparam int ADDR_W = addr_width(ROWS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_rd,
   input  logic [ADDR_W-1:0] copy_addr,
   output logic [DATA_W-1:0] copy_rd
);

   localparam bit FULL = (ROWS == (1 << ADDR_W));

   logic [DATA_W-1:0] mem_q [ROWS];
   logic [DATA_W-1:0] mem_d [ROWS];
   logic              waddr_ok;
   logic              disp_ok;
   logic              copy_ok;

   // Out-of-range row indices only exist when ROWS is not a power of two
   generate
      if (FULL) begin : g_full
         assign waddr_ok = 1'b1;
         assign disp_ok  = 1'b1;
         assign copy_ok  = 1'b1;
      end else begin : g_part
         localparam logic [ADDR_W:0] ROWS_LIM = (ADDR_W+1)'(ROWS);
         assign waddr_ok = ({1'b0, waddr}     < ROWS_LIM);
         assign disp_ok  = ({1'b0, disp_addr} < ROWS_LIM);
         assign copy_ok  = ({1'b0, copy_addr} < ROWS_LIM);
      end
   endgenerate

   // Next contents: unchanged except the addressed row on a valid write
   always_comb begin
      mem_d = mem_q;
      if (we && waddr_ok) begin
         mem_d[waddr] = wdata;
      end
   end

   // Row registers with synchronous clear
   always_ff @(posedge clk) begin
      for (int i = 0; i < ROWS; i++) begin
         mem_q[i] <= reset ? '0 : mem_d[i];
      end
   end

   // Read ports return zero for rows that do not exist
   always_comb begin
      disp_rd = disp_ok ? mem_q[disp_addr] : '0;
      copy_rd = copy_ok ? mem_q[copy_addr] : '0;
   end

endmodule

// File: rtl/matrix_fb_ctrl.sv
// Double-buffered LED matrix frame buffer controller: host writes the back
// bank, a swap request flips banks on the next frame wrap of the scanner.
// Optional feature macro: MATRIX_FB_COPY_EN (copy new front into new back).
module matrix_fb_ctrl
   import matrix_pkg::*;
#(
   parameter int  DATA_W = DATA_W_DEF,
   parameter int  ROWS   = ROWS_DEF,
   localparam int ADDR_W = addr_width(ROWS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              swap_req,
   output logic              swap_ack,
   output logic              front_sel
);

   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

   fb_state_e         state_q, state_d;
   logic              front_sel_q, front_sel_d;
   logic              ack_q, ack_d;
   logic [ADDR_W-1:0] samp0_q, samp0_d;
   logic [ADDR_W-1:0] samp1_q, samp1_d;
   logic              frame_tick;
   logic              host_we;
   logic              copy_we;
   logic [ADDR_W-1:0] copy_addr;
   logic [DATA_W-1:0] copy_data;
   logic [1:0]        bank_we;
   logic [ADDR_W-1:0] bank_waddr;
   logic [DATA_W-1:0] bank_wdata;
   logic [DATA_W-1:0] disp_rd [2];
   logic [DATA_W-1:0] copy_rd [2];

`ifdef MATRIX_FB_COPY_EN
   logic [ADDR_W-1:0] copy_cnt_q, copy_cnt_d;
`endif

   // Scanner sampler: a wrap from the last row to row 0 marks a frame boundary
   always_comb begin
      samp0_d    = disp_addr;
      samp1_d    = samp0_q;
      frame_tick = (samp1_q == LAST_ROW) && (samp0_q == '0);
   end

   // Swap sequencing: wait for a frame boundary, flip banks, optionally copy, acknowledge
   always_comb begin
      state_d     = state_q;
      front_sel_d = front_sel_q;
      ack_d       = 1'b0;
      wr_ready    = 1'b0;
      copy_we     = 1'b0;
`ifdef MATRIX_FB_COPY_EN
      copy_cnt_d  = copy_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            wr_ready = 1'b1;
            if (swap_req) begin
               state_d = ST_WAIT_FRAME;
            end
         end
         ST_WAIT_FRAME: begin
            if (frame_tick) begin
               state_d = ST_SWAP;
            end
         end
         ST_SWAP: begin
            front_sel_d = ~front_sel_q;
`ifdef MATRIX_FB_COPY_EN
            state_d     = ST_COPY;
            copy_cnt_d  = '0;
`else
            state_d     = ST_IDLE;
            ack_d       = 1'b1;
`endif
         end
`ifdef MATRIX_FB_COPY_EN
         ST_COPY: begin
            copy_we = 1'b1;
            if (copy_cnt_q == LAST_ROW) begin
               state_d = ST_IDLE;
               ack_d   = 1'b1;
            end else begin
               copy_cnt_d = copy_cnt_q + ADDR_W'(1);
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (reset) begin
         wr_ready = 1'b0;
      end
   end

   // Control registers; reset abandons any swap in flight without an acknowledge
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         front_sel_q <= 1'b0;
         ack_q       <= 1'b0;
         samp0_q     <= '0;
         samp1_q     <= '0;
      end else begin
         state_q     <= state_d;
         front_sel_q <= front_sel_d;
         ack_q       <= ack_d;
         samp0_q     <= samp0_d;
         samp1_q     <= samp1_d;
      end
   end

`ifdef MATRIX_FB_COPY_EN
   // Copy row counter walks the rows once after each swap
   always_ff @(posedge clk) begin
      if (reset) begin
         copy_cnt_q <= '0;
      end else begin
         copy_cnt_q <= copy_cnt_d;
      end
   end

   // Copy source is the freshly displayed bank
   always_comb begin
      copy_addr = copy_cnt_q;
      copy_data = copy_rd[front_sel_q];
   end
`else
   logic unused_copy_rd;

   // Without the copy feature the copy read ports are idle
   always_comb begin
      copy_addr      = '0;
      copy_data      = '0;
      unused_copy_rd = ^{copy_rd[0], copy_rd[1]};
   end
`endif

   // Write steering: only the bank not on display is ever written
   always_comb begin
      host_we    = wr_en && wr_ready;
      bank_waddr = copy_we ? copy_addr : wr_addr;
      bank_wdata = copy_we ? copy_data : wr_data;
      bank_we[0] = (host_we || copy_we) && front_sel_q;
      bank_we[1] = (host_we || copy_we) && !front_sel_q;
   end

   generate
      for (genvar b = 0; b < 2; b++) begin : g_bank
         matrix_fb_bank #(
            .DATA_W (DATA_W),
            .ROWS   (ROWS)
         ) u_bank (
            .clk       (clk),
            .reset     (reset),
            .we        (bank_we[b]),
            .waddr     (bank_waddr),
            .wdata     (bank_wdata),
            .disp_addr (disp_addr),
            .disp_rd   (disp_rd[b]),
            .copy_addr (copy_addr),
            .copy_rd   (copy_rd[b])
         );
      end
   endgenerate

   assign disp_data = disp_rd[front_sel_q];
   assign swap_ack  = ack_q;
   assign front_sel = front_sel_q;

endmodule

// File: tb/tb_matrix_fb_ctrl.sv
// Self-checking bench for matrix_fb_ctrl: directed vector table, hand-written
// swap/copy/reset sequences, then randomized traffic against a frame-level model.
module tb_matrix_fb_ctrl;

   localparam int DATA_W = 8;
   localparam int ROWS   = 8;
   localparam int ADDR_W = 3;
`ifdef MATRIX_FB_COPY_EN
   localparam int COPY_ROWS = ROWS;
`else
   localparam int COPY_ROWS = 0;
`endif
   localparam int SWAP_TO_ACK = COPY_ROWS + 1;

   logic              clk       = 1'b0;
   logic              reset     = 1'b1;
   logic [ADDR_W-1:0] disp_addr = '0;
   logic [DATA_W-1:0] disp_data;
   logic              wr_en     = 1'b0;
   logic [ADDR_W-1:0] wr_addr   = '0;
   logic [DATA_W-1:0] wr_data   = '0;
   logic              wr_ready;
   logic              swap_req  = 1'b0;
   logic              swap_ack;
   logic              front_sel;

   int n_cmp  = 0;
   int n_fail = 0;

   matrix_fb_ctrl #(.DATA_W(DATA_W), .ROWS(ROWS)) dut (
      .clk       (clk),
      .reset     (reset),
      .disp_addr (disp_addr),
      .disp_data (disp_data),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .swap_req  (swap_req),
      .swap_ack  (swap_ack),
      .front_sel (front_sel)
   );

   always #5 clk = ~clk;

   // Frame-level reference: two row arrays, which one is shown, and a swap timeline
   logic [DATA_W-1:0] m_bank [2][ROWS];
   int m_front     = 0;
   bit m_accepting = 1'b1;
   bit m_waiting   = 1'b0;
   int m_phase     = -1;
   bit m_ack       = 1'b0;
   int m_prev      = 0;
   int m_last      = 0;

   task automatic model_edge();
      bit tick;
      if (reset) begin
         for (int b = 0; b < 2; b++)
            for (int r = 0; r < ROWS; r++) m_bank[b][r] = '0;
         m_front = 0; m_accepting = 1'b1; m_waiting = 1'b0;
         m_phase = -1; m_ack = 1'b0; m_prev = 0; m_last = 0;
         return;
      end
      tick  = (m_prev == ROWS - 1) && (m_last == 0);
      m_ack = 1'b0;
      if (m_accepting) begin
         if (wr_en) m_bank[1 - m_front][int'(wr_addr)] = wr_data;
         if (swap_req) begin
            m_accepting = 1'b0;
            m_waiting   = 1'b1;
         end
      end else if (m_waiting) begin
         if (tick) begin
            m_waiting = 1'b0;
            m_phase   = 0;
         end
      end else if (m_phase >= 0) begin
         if (m_phase == 0) m_front = 1 - m_front;
         else m_bank[1 - m_front][m_phase - 1] = m_bank[m_front][m_phase - 1];
         if (m_phase == COPY_ROWS) begin
            m_accepting = 1'b1;
            m_ack       = 1'b1;
            m_phase     = -1;
         end else begin
            m_phase++;
         end
      end
      m_prev = m_last;
      m_last = int'(disp_addr);
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: DUT and model both see the inputs held across the edge
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic check_model();
      check_output("wr_ready",  {31'd0, wr_ready},  {31'd0, m_accepting && !reset});
      check_output("swap_ack",  {31'd0, swap_ack},  {31'd0, m_ack});
      check_output("front_sel", {31'd0, front_sel}, m_front);
      check_output("disp_data", {24'd0, disp_data}, {24'd0, m_bank[m_front][int'(disp_addr)]});
   endtask

   task automatic apply_stimulus(input bit rst, input int da, input bit we, input int wa,
                                 input int wd, input bit sr);
      reset     = rst;
      disp_addr = ADDR_W'(da);
      wr_en     = we;
      wr_addr   = ADDR_W'(wa);
      wr_data   = DATA_W'(wd);
      swap_req  = sr;
   endtask

   // Steps until swap_ack is seen; returns -1 when it never comes
   task automatic wait_ack(input int limit, output int lat);
      lat = -1;
      for (int k = 1; k <= limit; k++) begin
         step();
         check_model();
         if (swap_ack === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   // Sweep the display address combinationally; row 3 and row 5 may hold data
   task automatic check_rows(input string tag, input int row3, input int row5);
      int exp;
      for (int r = 0; r < ROWS; r++) begin
         disp_addr = ADDR_W'(r);
         #1;
         exp = (r == 3) ? row3 : (r == 5) ? row5 : 0;
         check_output($sformatf("%s_row%0d", tag, r), {24'd0, disp_data}, exp);
      end
   endtask

   // Drive the scanner 1..7 then 0; the frame tick follows on the next cycle
   task automatic scan_to_wrap(input bit sr);
      for (int r = 1; r < ROWS; r++) begin
         apply_stimulus(1'b0, r, 1'b0, 0, 0, sr);
         step();
         check_model();
      end
      apply_stimulus(1'b0, 0, 1'b0, 0, 0, sr);
      step();
      check_model();
   endtask

   typedef struct {
      bit rst; int da; bit we; int wa; int wd; bit sr;
      bit e_ready; bit e_ack; bit e_fs; int e_data;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit rst, int da, bit we, int wa, int wd, bit sr,
                               bit e_ready, bit e_ack, bit e_fs, int e_data);
      vec_t v;
      v = '{rst, da, we, wa, wd, sr, e_ready, e_ack, e_fs, e_data};
      return v;
   endfunction

   initial begin
      int lat;

      // Reset, blank scan, write row 3, swap request on a wrap tick (ignored),
      // write attempt while waiting, scan to wrap, tick enters the swap
      tbl.push_back(mk(1, 0, 0, 0, 0,    0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0,    0, 0, 0, 0, 0));
      for (int r = 0; r < ROWS; r++) tbl.push_back(mk(0, r, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 3, 'hA5, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0,    1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 2, 'h3C, 1, 0, 0, 0, 0));
      for (int r = 2; r < ROWS; r++) tbl.push_back(mk(0, r, 0, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0,    1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0,    1, 0, 0, 0, 0));

      foreach (tbl[i]) begin
         apply_stimulus(tbl[i].rst, tbl[i].da, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].sr);
         step();
         check_output($sformatf("vec%0d_ready", i), {31'd0, wr_ready},  {31'd0, tbl[i].e_ready});
         check_output($sformatf("vec%0d_ack", i),   {31'd0, swap_ack},  {31'd0, tbl[i].e_ack});
         check_output($sformatf("vec%0d_fs", i),    {31'd0, front_sel}, {31'd0, tbl[i].e_fs});
         check_output($sformatf("vec%0d_data", i),  {24'd0, disp_data}, tbl[i].e_data);
      end

      // Swap in progress; drop the request early, it must still complete
      apply_stimulus(1'b0, 3, 1'b0, 0, 0, 1'b0);
      wait_ack(ROWS + 6, lat);
      check_output("swap1_ack_latency", lat, SWAP_TO_ACK);
      check_output("swap1_front_sel", {31'd0, front_sel}, 1);
      step();
      check_model();
      check_output("swap1_ack_single", {31'd0, swap_ack}, 0);
      check_rows("swap1", 'hA5, 0);

      // Second swap: row 3 survives only when the back bank was refreshed by the copy
      apply_stimulus(1'b0, 0, 1'b0, 0, 0, 1'b1);
      step();
      check_model();
      scan_to_wrap(1'b1);
      apply_stimulus(1'b0, 0, 1'b0, 0, 0, 1'b0);
      step();
      check_model();
      wait_ack(ROWS + 6, lat);
      check_output("swap2_ack_latency", lat, SWAP_TO_ACK);
      check_output("swap2_front_sel", {31'd0, front_sel}, 0);
      check_rows("swap2", (COPY_ROWS != 0) ? 'hA5 : 0, 0);

      // Abort a swap with reset: nothing acknowledged, everything cleared
      apply_stimulus(1'b0, 0, 1'b1, 5, 'h77, 1'b0);
      step();
      check_model();
      apply_stimulus(1'b0, 0, 1'b0, 0, 0, 1'b1);
      step();
      check_model();
`ifdef MATRIX_FB_COPY_EN
      scan_to_wrap(1'b1);
      for (int k = 0; k < 3; k++) begin
         apply_stimulus(1'b0, 0, 1'b0, 0, 0, 1'b1);
         step();
         check_model();
      end
      check_output("abort_in_copy_front", {31'd0, front_sel}, 1);
`endif
      apply_stimulus(1'b1, 0, 1'b0, 0, 0, 1'b0);
      step();
      check_model();
      apply_stimulus(1'b0, 0, 1'b0, 0, 0, 1'b0);
      wait_ack(ROWS + 4, lat);
      check_output("abort_no_ack", lat, -1);
      check_output("abort_front_sel", {31'd0, front_sel}, 0);
      check_rows("abort", 0, 0);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         int da;
         bit sr;
         da = ($urandom_range(0, 3) != 0) ? (int'(disp_addr) + 1) % ROWS
                                          : int'($urandom_range(0, ROWS - 1));
         sr = swap_req;
         if (!sr && $urandom_range(0, 15) == 0) sr = 1'b1;
         else if (sr && $urandom_range(0, 29) == 0) sr = 1'b0;
         apply_stimulus($urandom_range(0, 299) == 0, da, $urandom_range(0, 1) == 1,
                        int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, 255)), sr);
         step();
         check_model();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
